// File: rtl/vga_timing_generator.sv
// vga_timing_generator: parametrised VESA-style raster timing generator.
// Produces a registered cursor, sync pulses with selectable polarity,
// active-video flag, line/frame start strobes and a frame counter, all
// aligned to the same cursor cycle and advanced only when i_Enable is high.
module vga_timing_generator #(
    parameter int unsigned ACTIVE_COLS = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned ACTIVE_ROWS = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        H_POL       = 1'b0,
    parameter logic        V_POL       = 1'b0,
    parameter int unsigned CW          = 10
) (
    input  logic          i_Clk,
    input  logic          i_Reset,
    input  logic          i_Enable,
    output logic          o_H_Sync,
    output logic          o_V_Sync,
    output logic          o_Active,
    output logic [CW-1:0] o_X_Cursor,
    output logic [CW-1:0] o_Y_Cursor,
    output logic          o_Line_Start,
    output logic          o_Frame_Start,
    output logic [7:0]    o_Frame_Count
);

    localparam int unsigned TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST     = CW'(TOTAL_COLS - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(TOTAL_ROWS - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(ACTIVE_COLS);
    localparam logic [CW-1:0] V_ACT_END  = CW'(ACTIVE_ROWS);
    localparam logic [CW-1:0] HS_START   = CW'(ACTIVE_COLS + H_FRONT);
    localparam logic [CW-1:0] HS_END     = CW'(ACTIVE_COLS + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_START   = CW'(ACTIVE_ROWS + V_FRONT);
    localparam logic [CW-1:0] VS_END     = CW'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [7:0]    fc_q, fc_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          act_q, act_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // Next cursor/counter and flags derived from the next cursor, so the
    // registered flags always describe the cursor shown alongside them.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (i_Enable) begin
            if (x_q == H_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fc_d = fc_q + 8'd1;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        hs_d  = ((x_d >= HS_START) && (x_d <= HS_END)) ? H_POL : ~H_POL;
        vs_d  = ((y_d >= VS_START) && (y_d <= VS_END)) ? V_POL : ~V_POL;
        act_d = (x_d < H_ACT_END) && (y_d < V_ACT_END);
    end

    // State and output registers; reset leaves the cursor at (0,0) unstrobed.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            x_q   <= '0;
            y_q   <= '0;
            fc_q  <= '0;
            hs_q  <= ~H_POL;
            vs_q  <= ~V_POL;
            act_q <= 1'b1;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            fc_q  <= fc_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    assign o_X_Cursor    = x_q;
    assign o_Y_Cursor    = y_q;
    assign o_Frame_Count = fc_q;
    assign o_H_Sync      = hs_q;
    assign o_V_Sync      = vs_q;
    assign o_Active      = act_q;
    assign o_Line_Start  = ls_q;
    assign o_Frame_Start = fs_q;

endmodule
